// File: rtl/tt_sweep_capture.sv
// Sweep engine: walks every input vector of a small combinational block, captures
// its 1-bit response into a truth table and compares it against a latched expected table.
module tt_sweep_capture #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [(1 << N_IN)-1:0]   expected,
    input  logic                     resp,
    output logic [N_IN-1:0]          stim,
    output logic                     busy,
    output logic                     done,
    output logic [(1 << N_IN)-1:0]   table_out,
    output logic                     match,
    output logic [N_IN:0]            err_count,
    output logic [N_IN-1:0]          first_err
);

    // state    | meaning
    // S_IDLE   | waiting for start; results from the last sweep held
    // S_SETTLE | stim held while the function output settles
    // S_SAMPLE | resp captured into table at the closing edge
    // S_DONE   | one-cycle done pulse, results valid
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_e;

    localparam int         N_TAB       = 1 << N_IN;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_e            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_TAB-1:0]  table_q, table_d;
    logic [N_TAB-1:0]  exp_q, exp_d;
    logic              match_q, match_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   first_q, first_d;

    logic [N_TAB-1:0]  cap_table;
    logic [N_TAB-1:0]  diff;
    logic [N_IN:0]     diff_cnt;
    logic [N_IN-1:0]   diff_first;

    // Results are scored against the table including the entry captured this cycle.
    always_comb begin
        cap_table         = table_q;
        cap_table[stim_q] = resp;
        diff              = cap_table ^ exp_q;
        diff_cnt          = '0;
        diff_first        = '0;
        for (int i = N_TAB - 1; i >= 0; i--) begin
            if (diff[i]) begin
                diff_cnt   = diff_cnt + (N_IN + 1)'(1);
                diff_first = N_IN'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        exp_d   = exp_q;
        match_d = match_q;
        err_d   = err_q;
        first_d = first_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d   = expected;
                    table_d = '0;
                    err_d   = '0;
                    match_d = 1'b0;
                    first_d = '0;
                    stim_d  = '0;
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    stim_d  = '0;
                    match_d = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    stim_d  = '0;
                    match_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    table_d = cap_table;
                    if (stim_q == '1) begin
                        match_d = (diff_cnt == '0);
                        err_d   = diff_cnt;
                        first_d = diff_first;
                        stim_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        stim_d  = stim_q + N_IN'(1);
                        cnt_d   = SETTLE_LOAD;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stim_q  <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            exp_q   <= '0;
            match_q <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign stim      = stim_q;
    assign busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done      = (state_q == S_DONE);
    assign table_out = table_q;
    assign match     = match_q;
    assign err_count = err_q;
    assign first_err = first_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: sweeps a modelled truth table through the DUT and
// checks timing, captured table and comparison results against a reference model.
module tb_tt_sweep_capture;

    localparam int N   = 4;
    localparam int SET = 1;
    localparam int T   = 1 << N;
    localparam int SWEEP_CYC = T * (SET + 1);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [T-1:0]  expected;
    logic          resp;
    logic [N-1:0]  stim;
    logic          busy;
    logic          done;
    logic [T-1:0]  table_out;
    logic          match;
    logic [N:0]    err_count;
    logic [N-1:0]  first_err;

    logic [T-1:0]  fn_table;
    int            checks;
    int            errors;

    tt_sweep_capture #(.N_IN(N), .SETTLE(SET)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .expected  (expected),
        .resp      (resp),
        .stim      (stim),
        .busy      (busy),
        .done      (done),
        .table_out (table_out),
        .match     (match),
        .err_count (err_count),
        .first_err (first_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The function under test is whatever truth table the bench loads.
    assign resp = fn_table[stim];

    function automatic logic [T-1:0] nominal_fn();
        logic [T-1:0] t;
        logic [3:0]   v;
        logic         a, b, c, d;
        t = '0;
        for (int k = 0; k < T; k++) begin
            v = 4'(k);
            a = v[3]; b = v[2]; c = v[1]; d = v[0];
            t[k] = (b | c) & (a | ~b | ~c) & (~a | ~b | d);
        end
        return t;
    endfunction

    function automatic void model(input logic [T-1:0] tab, input logic [T-1:0] ex,
                                  output logic m, output logic [N:0] e, output logic [N-1:0] f);
        m = 1'b1; e = '0; f = '0;
        for (int k = T - 1; k >= 0; k--) begin
            if (tab[k] != ex[k]) begin
                m = 1'b0;
                e = e + (N + 1)'(1);
                f = N'(k);
            end
        end
    endfunction

    // mode 0: plain sweep; 1: start pulse + expected change at stim 3;
    // 2: abort at stim 5; 3: reset at stim 9.
    task automatic run_sweep(input logic [T-1:0] ex, input int mode,
                             output int cyc, output bit stim_ok, output bit done_seen);
        bit fired;
        int w;
        cyc = 0; stim_ok = 1'b1; done_seen = 1'b0; fired = 1'b0;
        w = 0;
        @(negedge clk);
        while ((busy || done) && w < 10) begin
            @(negedge clk);
            w++;
        end
        start    = 1'b1;
        expected = ex;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 200) begin
            if (done) begin
                done_seen = 1'b1;
                return;
            end
            if (stim !== N'(cyc / (SET + 1))) stim_ok = 1'b0;
            if (mode == 1 && stim == 4'd3 && !fired) begin
                start    = 1'b1;
                expected = '0;
                fired    = 1'b1;
            end
            if (mode == 2 && stim == 4'd5) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                return;
            end
            if (mode == 3 && stim == 4'd9) begin
                #2 rst_n = 1'b0;
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; expected = '0; fn_table = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (stim !== '0)      begin errors++; $display("FAIL reset_stim got %h want 0", stim); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (table_out !== '0) begin errors++; $display("FAIL reset_table got %h want 0", table_out); end
        checks++; if (match !== 1'b0)   begin errors++; $display("FAIL reset_match got %b want 0", match); end
        checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_err got %0d want 0", err_count); end
        checks++; if (first_err !== '0) begin errors++; $display("FAIL reset_first got %0d want 0", first_err); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        int cyc; bit sok, dseen;
        logic m; logic [N:0] e; logic [N-1:0] f;
        fn_table = nominal_fn();
        model(fn_table, 16'hAC3C, m, e, f);
        run_sweep(16'hAC3C, 0, cyc, sok, dseen);
        checks++; if (!dseen)           begin errors++; $display("FAIL nom_done got none want pulse"); end
        checks++; if (cyc != SWEEP_CYC) begin errors++; $display("FAIL nom_latency got %0d want %0d", cyc, SWEEP_CYC); end
        checks++; if (!sok)             begin errors++; $display("FAIL nom_stim_seq got bad want 0..15 x2"); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL nom_busy_at_done got %b want 0", busy); end
        checks++; if (table_out !== fn_table) begin errors++; $display("FAIL nom_table got %h want %h", table_out, fn_table); end
        checks++; if (match !== m)      begin errors++; $display("FAIL nom_match got %b want %b", match, m); end
        checks++; if (err_count !== e)  begin errors++; $display("FAIL nom_err got %0d want %0d", err_count, e); end
        checks++; if (first_err !== f)  begin errors++; $display("FAIL nom_first got %0d want %0d", first_err, f); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL nom_done_width got %b want 0", done); end
        checks++; if ({table_out, match, stim} !== {fn_table, m, 4'd0})
            begin errors++; $display("FAIL nom_hold got %h/%b/%h want %h/%b/0", table_out, match, stim, fn_table, m); end
    endtask

    task automatic test_mismatch_and_stuck();
        int cyc; bit sok, dseen;
        logic m; logic [N:0] e; logic [N-1:0] f;
        fn_table = nominal_fn();
        model(fn_table, 16'hAC3D, m, e, f);
        run_sweep(16'hAC3D, 0, cyc, sok, dseen);
        checks++; if ({dseen, match, err_count, first_err} !== {1'b1, m, e, f})
            begin errors++; $display("FAIL single_mm got d%b m%b e%0d f%0d want d1 m%b e%0d f%0d", dseen, match, err_count, first_err, m, e, f); end
        fn_table = '0;
        model(fn_table, 16'hFFFF, m, e, f);
        run_sweep(16'hFFFF, 0, cyc, sok, dseen);
        checks++; if (table_out !== 16'h0000) begin errors++; $display("FAIL stuck_table got %h want 0000", table_out); end
        checks++; if ({dseen, match, err_count, first_err} !== {1'b1, m, e, f})
            begin errors++; $display("FAIL stuck_result got d%b m%b e%0d f%0d want d1 m%b e%0d f%0d", dseen, match, err_count, first_err, m, e, f); end
    endtask

    task automatic test_random();
        int cyc; bit sok, dseen;
        logic m; logic [N:0] e; logic [N-1:0] f;
        logic [T-1:0] ex, mask;
        for (int it = 0; it < 8; it++) begin
            fn_table = T'($urandom);
            case ($urandom_range(0, 2))
                0:       mask = '0;
                1:       mask = T'(1) << $urandom_range(0, T - 1);
                default: mask = T'($urandom);
            endcase
            ex = fn_table ^ mask;
            model(fn_table, ex, m, e, f);
            run_sweep(ex, 0, cyc, sok, dseen);
            checks++; if ({dseen, cyc == SWEEP_CYC, sok, table_out} !== {3'b111, fn_table})
                begin errors++; $display("FAIL rand%0d_sweep got d%b c%0d s%b t%h want t%h", it, dseen, cyc, sok, table_out, fn_table); end
            checks++; if ({match, err_count, first_err} !== {m, e, f})
                begin errors++; $display("FAIL rand%0d_result got m%b e%0d f%0d want m%b e%0d f%0d", it, match, err_count, first_err, m, e, f); end
        end
    endtask

    task automatic test_abort();
        int cyc; bit sok, dseen;
        int done_hits;
        fn_table = nominal_fn();
        run_sweep(16'hAC3C, 2, cyc, sok, dseen);
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (stim !== '0)    begin errors++; $display("FAIL abort_stim got %h want 0", stim); end
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL abort_match got %b want 0", match); end
        checks++; if (table_out !== (fn_table & 16'h001F))
            begin errors++; $display("FAIL abort_partial got %h want %h", table_out, fn_table & 16'h001F); end
        done_hits = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_hits++;
            @(posedge clk); #1;
        end
        checks++; if (done_hits != 0 || busy !== 1'b0)
            begin errors++; $display("FAIL abort_no_done got %0d pulses busy %b want 0 0", done_hits, busy); end
        run_sweep(16'hAC3C, 0, cyc, sok, dseen);
        checks++; if ({dseen, match, table_out} !== {2'b11, fn_table})
            begin errors++; $display("FAIL abort_rerun got d%b m%b t%h want d1 m1 t%h", dseen, match, table_out, fn_table); end
    endtask

    task automatic test_ignored_start();
        int cyc; bit sok, dseen;
        fn_table = nominal_fn();
        run_sweep(16'hAC3C, 1, cyc, sok, dseen);
        checks++; if (!dseen || cyc != SWEEP_CYC)
            begin errors++; $display("FAIL ign_latency got d%b c%0d want d1 c%0d", dseen, cyc, SWEEP_CYC); end
        checks++; if (!sok) begin errors++; $display("FAIL ign_stim_seq got bad want 0..15 x2"); end
        checks++; if ({match, err_count, table_out} !== {1'b1, 5'd0, fn_table})
            begin errors++; $display("FAIL ign_result got m%b e%0d t%h want m1 e0 t%h", match, err_count, table_out, fn_table); end
        expected = 16'hAC3C;
    endtask

    task automatic test_reset_mid();
        int cyc; bit sok, dseen;
        int done_hits;
        fn_table = nominal_fn();
        run_sweep(16'hAC3C, 3, cyc, sok, dseen);
        #1;
        checks++; if ({stim, busy, done} !== {4'd0, 2'b00})
            begin errors++; $display("FAIL rmid_ctrl got s%h b%b d%b want 0 0 0", stim, busy, done); end
        checks++; if ({table_out, match, err_count, first_err} !== '0)
            begin errors++; $display("FAIL rmid_results got t%h m%b e%0d f%0d want all 0", table_out, match, err_count, first_err); end
        done_hits = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_hits++;
        end
        checks++; if (done_hits != 0) begin errors++; $display("FAIL rmid_quiet got %0d active cycles want 0", done_hits); end
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(16'hAC3C, 0, cyc, sok, dseen);
        checks++; if ({dseen, cyc == SWEEP_CYC, sok, match, table_out} !== {4'b1111, fn_table})
            begin errors++; $display("FAIL rmid_rerun got d%b c%0d s%b m%b t%h want t%h", dseen, cyc, sok, match, table_out, fn_table); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_nominal();
        test_mismatch_and_stuck();
        test_random();
        test_abort();
        test_ignored_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
